vscale_wb_unit: RTL and testbench

- Writeback-side producer for the 2R/1W integer register file; sole driver of the regfile write port (wen/wa/wd).
- Merges two result sources into the single write port:
  - Source A: in-order pipeline result, always has priority.
  - Source B: long-latency result (mul/div, late load) with valid/ready handshake, buffered in a small FIFO.
- Holds a 32-entry pending scoreboard for issued long-latency ops and reports read-after-write hazards for the two regfile read addresses.

---
 rtl/vscale_wb_unit.sv | 149 ++++++++++++++
 tb/tb_vscale_wb_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_wb_unit.sv
// vscale_wb_unit: writeback-side producer for the integer register file.
// It merges in-order results (source A, always first) with long-latency
// results (source B, buffered in a small FIFO) onto the single registered
// write port. It also keeps a pending scoreboard for issued long-latency
// ops and reports read-after-write hazards on the two read addresses.
// Optional feature macro: VSCALE_WB_BYPASS_EN (forwards the registered write
// to the read ports instead of flagging it as a hazard).
//
// Handshake (source B): a transfer happens on a rising edge where
// b_valid && b_ready. b_ready depends only on FIFO occupancy, never on
// b_valid. Once b_valid is asserted, the producer keeps b_valid/b_wa/b_wd
// stable until the transfer completes.
module vscale_wb_unit #(
    parameter int XPR_LEN        = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int BUF_DEPTH      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      a_valid,
    input  logic [REG_ADDR_WIDTH-1:0] a_wa,
    input  logic [XPR_LEN-1:0]        a_wd,
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [REG_ADDR_WIDTH-1:0] b_wa,
    input  logic [XPR_LEN-1:0]        b_wd,
    input  logic                      iss_valid,
    input  logic [REG_ADDR_WIDTH-1:0] iss_wa,
    output logic                      iss_stall,
    input  logic [REG_ADDR_WIDTH-1:0] ra1,
    input  logic [REG_ADDR_WIDTH-1:0] ra2,
    output logic                      hazard1,
    output logic                      hazard2,
    output logic [XPR_LEN-1:0]        byp1_data,
    output logic [XPR_LEN-1:0]        byp2_data,
    output logic                      wen,
    output logic [REG_ADDR_WIDTH-1:0] wa,
    output logic [XPR_LEN-1:0]        wd
);

    localparam int NREG  = 1 << REG_ADDR_WIDTH;
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    // FIFO storage and bookkeeping
    logic [REG_ADDR_WIDTH-1:0] fifo_wa [BUF_DEPTH];
    logic [XPR_LEN-1:0]        fifo_wd [BUF_DEPTH];
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W-1:0]          wr_ptr;
    logic [CNT_W-1:0]          count;

    logic [NREG-1:0]           pending;

    logic                      fifo_empty;
    logic                      sel_a;
    logic                      push;
    logic                      pop;
    logic                      iss_set;
    logic [REG_ADDR_WIDTH-1:0] head_wa;
    logic [XPR_LEN-1:0]        head_wd;
    logic                      inflight1;
    logic                      inflight2;

    assign fifo_empty = (count == '0);
    assign b_ready    = (count != FULL_CNT);
    // x0 results are accepted but dropped, so they never occupy a slot.
    assign push       = b_valid && b_ready && (b_wa != '0);
    assign sel_a      = a_valid && (a_wa != '0);
    // Pop only what was already stored: no same-cycle pass-through.
    assign pop        = !sel_a && !fifo_empty;
    assign head_wa    = fifo_wa[rd_ptr];
    assign head_wd    = fifo_wd[rd_ptr];
    assign iss_set    = iss_valid && (iss_wa != '0);

    assign iss_stall  = iss_valid && pending[iss_wa];
    assign inflight1  = wen && (wa == ra1);
    assign inflight2  = wen && (wa == ra2);

`ifdef VSCALE_WB_BYPASS_EN
    // The registered write is forwarded, so only pending ops are hazards.
    assign hazard1   = (ra1 != '0) && pending[ra1];
    assign hazard2   = (ra2 != '0) && pending[ra2];
    assign byp1_data = (inflight1 && (ra1 != '0)) ? wd : '0;
    assign byp2_data = (inflight2 && (ra2 != '0)) ? wd : '0;
`else
    // Without forwarding the registered write is a hazard until it lands.
    assign hazard1   = (ra1 != '0) && (pending[ra1] || inflight1);
    assign hazard2   = (ra2 != '0) && (pending[ra2] || inflight2);
    assign byp1_data = '0;
    assign byp2_data = '0;
`endif

    // FIFO storage write; contents need no reset since count gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wa[wr_ptr] <= b_wa;
            fifo_wd[wr_ptr] <= b_wd;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered write port: A first, else FIFO head, else idle holding wa/wd.
    always_ff @(posedge clk) begin
        if (reset) begin
            wen <= 1'b0;
            wa  <= '0;
            wd  <= '0;
        end else if (sel_a) begin
            wen <= 1'b1;
            wa  <= a_wa;
            wd  <= a_wd;
        end else if (pop) begin
            wen <= 1'b1;
            wa  <= head_wa;
            wd  <= head_wd;
        end else begin
            wen <= 1'b0;
        end
    end

    // Pending scoreboard: clear on pop, set on issue (set wins), x0 never set.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (pop)     pending[head_wa] <= 1'b0;
            if (iss_set) pending[iss_wa]  <= 1'b1;
            pending[0] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vscale_wb_unit.sv
// Testbench for vscale_wb_unit: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the writeback unit.
module tb_vscale_wb_unit;

  localparam int XL = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;
  localparam int W = AW + XL;
`ifdef VSCALE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          a_valid, b_valid, iss_valid;
  logic [AW-1:0] a_wa, b_wa, iss_wa, ra1, ra2;
  logic [XL-1:0] a_wd, b_wd;
  logic          b_ready, iss_stall, hazard1, hazard2, wen;
  logic [XL-1:0] byp1_data, byp2_data, wd;
  logic [AW-1:0] wa;

  vscale_wb_unit #(.XPR_LEN(XL), .REG_ADDR_WIDTH(AW), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_wa(a_wa), .a_wd(a_wd),
    .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
    .iss_valid(iss_valid), .iss_wa(iss_wa), .iss_stall(iss_stall),
    .ra1(ra1), .ra2(ra2), .hazard1(hazard1), .hazard2(hazard2),
    .byp1_data(byp1_data), .byp2_data(byp2_data),
    .wen(wen), .wa(wa), .wd(wd)
  );

  // reference model state
  logic [W-1:0]  exp_q[$];
  logic [31:0]   pend = '0;
  logic          m_wen = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic [XL-1:0] m_wd = '0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    reset = 1'b0;
    a_valid = 1'b0; a_wa = '0; a_wd = '0;
    b_valid = 1'b0; b_wa = '0; b_wd = '0;
    iss_valid = 1'b0; iss_wa = '0;
    ra1 = '0; ra2 = '0;
  endtask

  function automatic logic m_hazard(input logic [AW-1:0] ra);
    return (ra != '0) && (pend[ra] || (!BYP && m_wen && m_wa == ra));
  endfunction

  function automatic logic [XL-1:0] m_byp(input logic [AW-1:0] ra);
    return (BYP && m_wen && m_wa == ra && ra != '0) ? m_wd : '0;
  endfunction

  // One clock: check combinational outputs against the model, step the
  // model with the inputs present at the edge, then check the write port.
  task automatic cycle();
    logic          n_wen;
    logic [AW-1:0] n_wa;
    logic [XL-1:0] n_wd;
    logic [W-1:0]  head;
    logic          accept;
    #1;
    check("b_ready", 32'(b_ready), 32'(exp_q.size() < DEPTH));
    check("iss_stall", 32'(iss_stall), 32'(iss_valid && pend[iss_wa]));
    check("hazard1", 32'(hazard1), 32'(m_hazard(ra1)));
    check("hazard2", 32'(hazard2), 32'(m_hazard(ra2)));
    check("byp1", byp1_data, m_byp(ra1));
    check("byp2", byp2_data, m_byp(ra2));
    accept = b_valid && (exp_q.size() < DEPTH);
    n_wen = 1'b0; n_wa = m_wa; n_wd = m_wd;
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      pend = '0;
      n_wen = 1'b0; n_wa = '0; n_wd = '0;
    end else begin
      if (a_valid && a_wa != '0) begin
        n_wen = 1'b1; n_wa = a_wa; n_wd = a_wd;
      end else if (exp_q.size() > 0) begin
        head = exp_q.pop_front();
        n_wen = 1'b1; n_wa = head[W-1:XL]; n_wd = head[XL-1:0];
        pend[n_wa] = 1'b0;
      end
      if (accept && b_wa != '0) exp_q.push_back({b_wa, b_wd});
      if (iss_valid && iss_wa != '0) pend[iss_wa] = 1'b1;
    end
    m_wen = n_wen; m_wa = n_wa; m_wd = n_wd;
    #1;
    check("wen", 32'(wen), 32'(m_wen));
    check("wa", 32'(wa), 32'(m_wa));
    check("wd", wd, m_wd);
  endtask

  initial begin
    int pa;
    drive_idle();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_wa", 32'(wa), 32'd0);
    check("rst_wd", wd, 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd1);

    // A write goes out one cycle later, then idles
    a_valid = 1'b1; a_wa = 5'd5; a_wd = 32'hDEADBEEF;
    cycle();
    check("a_wen", 32'(wen), 32'd1);
    check("a_wa", 32'(wa), 32'd5);
    check("a_wd", wd, 32'hDEADBEEF);
    drive_idle();
    cycle();
    check("a_wen_drop", 32'(wen), 32'd0);

    // long-latency result waits behind A traffic, clears pending after write
    iss_valid = 1'b1; iss_wa = 5'd7;
    cycle();
    drive_idle();
    ra1 = 5'd7;
    b_valid = 1'b1; b_wa = 5'd7; b_wd = 32'h1234;
    a_valid = 1'b1; a_wa = 5'd1; a_wd = $urandom;
    cycle();
    check("p7_hazard", 32'(hazard1), 32'd1);
    b_valid = 1'b0;
    cycle();
    cycle();
    a_valid = 1'b0;
    cycle();
    check("b7_wen", 32'(wen), 32'd1);
    check("b7_wa", 32'(wa), 32'd7);
    check("b7_wd", wd, 32'h1234);
    cycle();
    check("b7_hazard_clear", 32'(hazard1), 32'd0);

    // fill FIFO under A traffic, then drain in order
    drive_idle();
    a_valid = 1'b1; a_wa = 5'd3; a_wd = 32'h33;
    b_valid = 1'b1; b_wa = 5'd1; b_wd = 32'h11;
    cycle();
    b_wa = 5'd2; b_wd = 32'h22;
    cycle();
    check("full_ready", 32'(b_ready), 32'd0);
    drive_idle();
    cycle();
    check("drain1_wa", 32'(wa), 32'd1);
    check("drain1_ready", 32'(b_ready), 32'd1);
    cycle();
    check("drain2_wa", 32'(wa), 32'd2);

    // x0 traffic never writes and never sets pending
    a_valid = 1'b1; a_wa = '0; a_wd = 32'h5;
    b_valid = 1'b1; b_wa = '0; b_wd = 32'h6;
    iss_valid = 1'b1; iss_wa = '0;
    cycle();
    check("x0_wen", 32'(wen), 32'd0);
    cycle();
    check("x0_wen2", 32'(wen), 32'd0);
    check("x0_ready", 32'(b_ready), 32'd1);

    // WAW stall, then reset in the same cycle
    drive_idle();
    iss_valid = 1'b1; iss_wa = 5'd9;
    cycle();
    #1;
    check("waw_stall", 32'(iss_stall), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    check("post_rst_stall", 32'(iss_stall), 32'd0);
    check("post_rst_wen", 32'(wen), 32'd0);
    check("post_rst_ready", 32'(b_ready), 32'd1);

    // write then read the same register on the next cycle
    drive_idle();
    a_valid = 1'b1; a_wa = 5'd3; a_wd = 32'hCAFEF00D;
    cycle();
    drive_idle();
    ra1 = 5'd3;
    #1;
    check("rd3_hazard", 32'(hazard1), BYP ? 32'd0 : 32'd1);
    check("rd3_byp", byp1_data, BYP ? 32'hCAFEF00D : 32'd0);
    cycle();

    // randomized traffic in phases of varying A load
    for (int i = 0; i < 3000; i++) begin
      pa = (i / 250) % 4;
      reset = ($urandom_range(0, 299) == 0);
      a_valid = ($urandom_range(0, 3) < pa);
      a_wa = 5'($urandom_range(0, 7));
      a_wd = $urandom;
      if (!b_valid || b_ready) begin
        b_valid = ($urandom_range(0, 1) == 1);
        b_wa = 5'($urandom_range(0, 7));
        b_wd = $urandom;
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_wa = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7));
      ra2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
